// File: rtl/collatz_datapath_if.sv
// Operand/status bundle between the Lab3 controller and the collatz datapath.
// The controller drives operand and function select; the datapath returns status and observation.
interface collatz_datapath_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CW    = 8
);
    logic [WIDTH-1:0] DIN;
    logic             WEN;
    logic             SEL;
    logic [1:0]       FS;
    logic             One;
    logic             X0;
    logic [WIDTH-1:0] XOUT;
    logic [CW-1:0]    STEPS;
    logic [WIDTH-1:0] PEAK;
    logic             OVF;

    modport master (
        output DIN, WEN, SEL, FS,
        input  One, X0, XOUT, STEPS, PEAK, OVF
    );

    modport slave (
        input  DIN, WEN, SEL, FS,
        output One, X0, XOUT, STEPS, PEAK, OVF
    );
endinterface

// File: rtl/collatz_datapath.sv
// Collatz datapath: holds operand X, applies pass/halve/3X+1 on command and tracks
// step count, peak value and a sticky truncation flag.
module collatz_datapath #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CW    = 8
) (
    input logic               CLK,
    input logic               resetn,
    collatz_datapath_if.slave dp
);
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] peak_q, peak_d;
    logic [CW-1:0]    steps_q, steps_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] r;
    logic [WIDTH+1:0] ext;
    logic             ov;
    logic             alu_op;

    // 3X+1 at two extra bits so the carry-out into the top bits flags truncation
    assign ext = ({2'b00, x_q} << 1) + {2'b00, x_q} + (WIDTH + 2)'(1);

    always_comb begin
        r  = x_q;
        ov = 1'b0;
        case (dp.FS)
            2'b01: r = x_q >> 1;
            2'b10: begin
                r  = ext[WIDTH-1:0];
                ov = |ext[WIDTH+1:WIDTH];
            end
            default: r = x_q;
        endcase
    end

    assign alu_op = dp.WEN & dp.SEL & ((dp.FS == 2'b01) | (dp.FS == 2'b10));

    always_comb begin
        x_d     = x_q;
        steps_d = steps_q;
        peak_d  = peak_q;
        ovf_d   = ovf_q;
        if (dp.WEN && !dp.SEL) begin
            x_d     = dp.DIN;
            steps_d = '0;
            peak_d  = dp.DIN;
            ovf_d   = 1'b0;
        end else if (alu_op) begin
            x_d     = r;
            steps_d = (steps_q == '1) ? steps_q : steps_q + CW'(1);
            peak_d  = (r > peak_q) ? r : peak_q;
            ovf_d   = ovf_q | ov;
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            x_q     <= '0;
            steps_q <= '0;
            peak_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            x_q     <= x_d;
            steps_q <= steps_d;
            peak_q  <= peak_d;
            ovf_q   <= ovf_d;
        end
    end

    // Status comes from the register, so the controller sees it one cycle after the write
    assign dp.One   = (x_q == WIDTH'(1));
    assign dp.X0    = x_q[0];
    assign dp.XOUT  = x_q;
    assign dp.STEPS = steps_q;
    assign dp.PEAK  = peak_q;
    assign dp.OVF   = ovf_q;
endmodule

// File: tb/tb_collatz_datapath.sv
// Bench for collatz_datapath: directed vector table, hand-written corner sequences and
// random traffic against an arithmetic reference model; a CW=3 instance covers saturation.
module tb_collatz_datapath;
    logic CLK;
    logic resetn;

    collatz_datapath_if #(.WIDTH(16), .CW(8)) if_a ();
    collatz_datapath_if #(.WIDTH(16), .CW(3)) if_s ();

    collatz_datapath #(.WIDTH(16), .CW(8)) u_dut_a (.CLK(CLK), .resetn(resetn), .dp(if_a.slave));
    collatz_datapath #(.WIDTH(16), .CW(3)) u_dut_s (.CLK(CLK), .resetn(resetn), .dp(if_s.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state, shared by both instances except the step counters
    int m_x, m_peak, m_ovf, m_steps_a, m_steps_s;

    typedef struct {
        logic        wen;
        logic        sel;
        logic [1:0]  fs;
        logic [15:0] din;
        int          ex;
        int          es;
        int          ep;
        int          eo;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_x = 0; m_peak = 0; m_ovf = 0; m_steps_a = 0; m_steps_s = 0;
    endfunction

    function automatic void m_update(input logic wen, input logic sel, input logic [1:0] fs,
                                     input logic [15:0] din);
        int e;
        int res;
        if (!wen) return;
        if (!sel) begin
            m_x = din; m_peak = din; m_ovf = 0; m_steps_a = 0; m_steps_s = 0;
        end else if (fs == 2'd1 || fs == 2'd2) begin
            e   = (fs == 2'd1) ? m_x / 2 : 3 * m_x + 1;
            res = e % 65536;
            if (e >= 65536) m_ovf = 1;
            m_x = res;
            if (res > m_peak) m_peak = res;
            m_steps_a = (m_steps_a + 1 > 255) ? 255 : m_steps_a + 1;
            m_steps_s = (m_steps_s + 1 > 7) ? 7 : m_steps_s + 1;
        end
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".a.XOUT"}, int'(if_a.XOUT), m_x);
        chk({tag, ".a.STEPS"}, int'(if_a.STEPS), m_steps_a);
        chk({tag, ".a.PEAK"}, int'(if_a.PEAK), m_peak);
        chk({tag, ".a.OVF"}, int'(if_a.OVF), m_ovf);
        chk({tag, ".a.One"}, int'(if_a.One), (m_x == 1) ? 1 : 0);
        chk({tag, ".a.X0"}, int'(if_a.X0), m_x % 2);
        chk({tag, ".s.XOUT"}, int'(if_s.XOUT), m_x);
        chk({tag, ".s.STEPS"}, int'(if_s.STEPS), m_steps_s);
        chk({tag, ".s.PEAK"}, int'(if_s.PEAK), m_peak);
        chk({tag, ".s.OVF"}, int'(if_s.OVF), m_ovf);
    endtask

    task automatic drive(input logic wen, input logic sel, input logic [1:0] fs,
                         input logic [15:0] din);
        if_a.WEN = wen; if_a.SEL = sel; if_a.FS = fs; if_a.DIN = din;
        if_s.WEN = wen; if_s.SEL = sel; if_s.FS = fs; if_s.DIN = din;
    endtask

    // One edge: drive at negedge, sample 1ns after the rising edge
    task automatic step(input logic wen, input logic sel, input logic [1:0] fs,
                        input logic [15:0] din, input string tag);
        @(negedge CLK);
        resetn = 1'b1;
        drive(wen, sel, fs, din);
        @(posedge CLK);
        #1;
        m_update(wen, sel, fs, din);
        check_model(tag);
    endtask

    task automatic async_reset(input string tag);
        resetn = 1'b0;
        #1;
        m_reset();
        check_model(tag);
    endtask

    function automatic void add(input logic wen, input logic sel, input logic [1:0] fs,
                                input logic [15:0] din, input int ex, input int es,
                                input int ep, input int eo);
        vec_t v;
        v.wen = wen; v.sel = sel; v.fs = fs; v.din = din;
        v.ex = ex; v.es = es; v.ep = ep; v.eo = eo;
        tbl.push_back(v);
    endfunction

    int traj27[10] = '{82, 41, 124, 62, 31, 94, 47, 142, 71, 214};

    initial begin
        // Reset held with random inputs: outputs must be zero without any write taking effect
        resetn = 1'b0;
        m_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'($urandom), 2'($urandom), 16'($urandom));
            #3;
            check_model("rst_hold");
        end
        step(1'b0, 1'b0, 2'b00, 16'h1234, "rst_release");
        step(1'b0, 1'b1, 2'b10, 16'h0000, "rst_release2");

        // Directed table: sequence from 6, overflow, hold/no-op
        add(1, 0, 2'b00, 16'd6, 6, 0, 6, 0);
        add(1, 1, 2'b01, 16'd0, 3, 1, 6, 0);
        add(1, 1, 2'b10, 16'd0, 10, 2, 10, 0);
        add(1, 1, 2'b01, 16'd0, 5, 3, 10, 0);
        add(1, 1, 2'b10, 16'd0, 16, 4, 16, 0);
        add(1, 1, 2'b01, 16'd0, 8, 5, 16, 0);
        add(1, 1, 2'b01, 16'd0, 4, 6, 16, 0);
        add(1, 1, 2'b01, 16'd0, 2, 7, 16, 0);
        add(1, 1, 2'b01, 16'd0, 1, 8, 16, 0);
        add(1, 0, 2'b10, 16'hAAAB, 'hAAAB, 0, 'hAAAB, 0);
        add(1, 1, 2'b10, 16'd0, 2, 1, 'hAAAB, 1);
        add(1, 0, 2'b00, 16'd5, 5, 0, 5, 0);
        add(1, 1, 2'b10, 16'd0, 16, 1, 16, 0);
        add(1, 0, 2'b00, 16'd7, 7, 0, 7, 0);
        add(0, 1, 2'b10, 16'd9, 7, 0, 7, 0);
        add(0, 0, 2'b10, 16'd9, 7, 0, 7, 0);
        add(0, 1, 2'b10, 16'd9, 7, 0, 7, 0);
        add(1, 1, 2'b11, 16'd9, 7, 0, 7, 0);
        add(1, 1, 2'b00, 16'd9, 7, 0, 7, 0);

        foreach (tbl[i]) begin
            step(tbl[i].wen, tbl[i].sel, tbl[i].fs, tbl[i].din, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.XOUT", i), int'(if_a.XOUT), tbl[i].ex);
            chk($sformatf("vec%0d.STEPS", i), int'(if_a.STEPS), tbl[i].es);
            chk($sformatf("vec%0d.PEAK", i), int'(if_a.PEAK), tbl[i].ep);
            chk($sformatf("vec%0d.OVF", i), int'(if_a.OVF), tbl[i].eo);
            chk($sformatf("vec%0d.One", i), int'(if_a.One), (tbl[i].ex == 1) ? 1 : 0);
            chk($sformatf("vec%0d.X0", i), int'(if_a.X0), tbl[i].ex % 2);
        end

        // Saturation on the CW=3 instance along the 27 trajectory
        step(1'b1, 1'b0, 2'b00, 16'd27, "sat_load");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, if_s.X0 ? 2'b10 : 2'b01, 16'd0, "sat");
            chk("sat.x", int'(if_s.XOUT), traj27[i]);
            chk("sat.steps", int'(if_s.STEPS), (i + 1 > 7) ? 7 : i + 1);
        end

        // Reset asserted between edges mid-run
        step(1'b1, 1'b0, 2'b00, 16'd6, "mid_load");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, if_a.X0 ? 2'b10 : 2'b01, 16'd0, "mid_op");
        drive(1'b1, 1'b1, 2'b10, 16'd0);
        async_reset("mid_rst");
        chk("mid_rst.before_edge", (CLK == 1'b1) ? 1 : 0, 1);
        step(1'b1, 1'b0, 2'b00, 16'd3, "mid_reload");
        step(1'b1, 1'b1, 2'b10, 16'd0, "mid_op1");
        chk("mid_op1.x", int'(if_a.XOUT), 10);
        chk("mid_op1.steps", int'(if_a.STEPS), 1);

        // Random traffic against the model, with occasional async resets
        for (int i = 0; i < 400; i++) begin
            logic [15:0] din;
            din = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(21845, 65535))
                                              : 16'($urandom);
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 5) != 0), 2'($urandom), din,
                 "rnd");
            if ($urandom_range(0, 59) == 0) async_reset("rnd_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/collatz_datapath.md
# collatz_datapath

Datapath half of the Lab3 controller/datapath pair. It holds the working operand X and executes the function the controller selects on WEN/SEL/FS. It returns the status bits One and X0 that the controller branches on. It also keeps a step counter, a peak-value register and a sticky overflow flag for observation.

## Interface
Parameters:
- WIDTH, 16, width of X, DIN, XOUT and PEAK (minimum 4)
- CW, 8, width of the step counter

Ports:
- CLK  input  1  single clock; all state updates on the rising edge
- resetn  input  1  asynchronous, active-low reset; clears all state immediately
- DIN  input  WIDTH  starting operand, loaded when SEL=0
- WEN  input  1  write enable for X and the bookkeeping registers
- SEL  input  1  0 selects DIN as the next X; 1 selects the ALU result
- FS  input  2  ALU function select, used only when SEL=1
- One  output  1  combinational; 1 iff X == 1
- X0  output  1  combinational; equals X[0]
- XOUT  output  WIDTH  current X register
- STEPS  output  CW  number of ALU operations since the last load
- PEAK  output  WIDTH  largest X value since the last load
- OVF  output  1  sticky; set when a 3X+1 result is truncated

## Operation
ALU result R, by FS:
- 00: R = X (pass)
- 01: R = X >> 1 (logical right shift; MSB filled with 0)
- 10: R = 3X + 1, computed at WIDTH+2 bits and truncated to WIDTH. Let E be the unsigned extended result. OV = (E >= 2^WIDTH).
- 11: hold. No state changes, even with WEN=1.

Update rules at the rising CLK edge with resetn=1:
- WEN=0: all registers hold.
- WEN=1, SEL=0 (load): X←DIN, STEPS←0, PEAK←DIN, OVF←0. FS is ignored.
- WEN=1, SEL=1, FS=00: X←X. STEPS, PEAK and OVF hold.
- WEN=1, SEL=1, FS∈{01,10}:
  - X←R
  - STEPS←STEPS+1, saturating at 2^CW−1
  - PEAK←R if R > PEAK (unsigned), else hold
  - OVF←OVF | OV (OV is 0 for FS=01)
- When OVF=1, PEAK compares against the truncated R.

Status outputs:
- One and X0 are decoded combinationally from the X register, not from R. The controller therefore sees the new status in the cycle after the write edge.
- X = 0 gives One=0 and X0=0. FS=01 on X = 0 keeps X at 0 and still increments STEPS. The datapath does not guard against this; the controller must never request it.

Reset:
- resetn=0 forces X=0, STEPS=0, PEAK=0, OVF=0 asynchronously, independent of CLK.
- Resulting output values: One=0, X0=0, XOUT=0, STEPS=0, PEAK=0, OVF=0.
- Release is synchronous to the next CLK edge. The first edge with resetn=1 applies the normal update rules.

## Timing
- Write latency is 1 cycle. Inputs are sampled at edge n, and XOUT/STEPS/PEAK/OVF/One/X0 reflect the result after edge n.
- There is no handshake. Every edge with WEN=1 performs exactly one operation. Back-to-back operations on consecutive edges are supported at full rate.
- The combinational path from DIN/FS/X to R to the X D-input must close in one CLK period. The 3X+1 adder is the critical path.
- If resetn asserts mid-sequence, the in-flight operation is discarded. No partial update is permitted on the edge coincident with reset assertion.

## Test plan
- Reset: drive resetn=0 with random DIN/WEN/FS and no CLK edges. All outputs must be 0 immediately. After release with WEN=0, all outputs must stay 0.
- Full sequence from 6: load DIN=6, then drive FS=01 when X0=0 and FS=10 when X0=1, until One=1.
  - X must go 6,3,10,5,16,8,4,2,1.
  - End state: STEPS=8, PEAK=16, OVF=0, One=1, X0=1.
- Overflow (WIDTH=16): load 0xAAAB, then apply FS=10.
  - Result: X=0x0002, OVF=1, STEPS=1, PEAK=0xAAAB.
  - Reloading DIN=5 must clear OVF to 0 and set PEAK to 5.
- Hold and no-op: after loading 7, apply WEN=0 with FS=10 for 3 cycles, then WEN=1 with FS=11, then WEN=1 with FS=00. X must stay 7 and STEPS must stay 0 throughout.
- Saturation (CW=3): load 27 and apply 10 legal operations. STEPS must read 1..7, then hold at 7. X must follow the 27 trajectory exactly: 82,41,124,62,31,94,47,142,71,214.
- Async reset mid-run: load 6 and apply 3 operations. Assert resetn between edges; outputs must clear before the next edge. Release, load 3; after 1 op X=10 and STEPS=1.
